uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised UART receiver with 16x oversampling, runtime baud divisor, configurable data-bit count and an integrated receive FIFO. Error reporting covers framing errors, overruns and (optionally) parity errors. It sits between the uio RX pin and on-chip consumers, such as the UART transmitter or a command decoder. It replaces the fixed 8-bit receiver plus external FIFO glue with a single valid/ready stream source.

Parameters:
DATA_BITS, 8, frame payload width, legal 5..8
FIFO_DEPTH, 8, entries, power of 2, >= 2
DIV_W, 16, width of cfg_div
CNT_W, $clog2(FIFO_DEPTH+1), width of level

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx  in  1  raw serial input, idle high, asynchronous to clk
cfg_div  in  DIV_W  clk cycles per 1/16 bit; 0 treated as 1
m_data  out  DATA_BITS  head-of-FIFO byte, LSB = first bit received
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts m_data when m_valid && m_ready
level  out  CNT_W  FIFO occupancy
frame_err  out  1  one-cycle pulse: stop bit sampled 0
parity_err  out  1  one-cycle pulse: parity mismatch
overrun  out  1  one-cycle pulse: good frame dropped because FIFO full
ovr_cnt  out  8  saturating count of overruns
busy  out  1  FSM not IDLE

Behaviour:
- Reset values: m_valid=0, level=0, m_data=0, all pulses=0, ovr_cnt=0, busy=0. FSM goes to IDLE; synchroniser flops are set to 1.
- rx passes through a 2-flop synchroniser; all sampling uses the synchronised value.
- Tick generator: counter runs 0..div-1 and emits a tick on div-1. div is latched from cfg_div only while in IDLE, so a cfg_div change mid-frame takes effect at the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HI.
  - IDLE: when synchronised rx=0, clear the tick and sample counters and enter START.
  - START: at the 8th tick (mid-bit), rx=0 goes to DATA; rx=1 is a glitch and returns to IDLE silently.
  - DATA: every 16 ticks, shift in one bit LSB-first; after DATA_BITS bits go to PARITY if the feature is present, else STOP.
  - STOP: sample 16 ticks after the last bit. rx=1 goes to IDLE and the byte is pushed. rx=0 pulses frame_err, discards the byte and goes to WAIT_HI.
  - WAIT_HI: stay until synchronised rx=1, then go to IDLE. A line break therefore produces exactly one frame_err.
- Push happens in the cycle after the stop-bit sample. m_valid and level update in the following cycle. m_data is first-word-fallthrough and is stable while m_valid && !m_ready.
- Full FIFO: a good frame is dropped, overrun pulses and ovr_cnt increments, saturating at 255. Stored data is unaffected.
- Push and pop in the same cycle, including when full: both take effect and level is unchanged.
- Pop with the FIFO empty is ignored.
- Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full/empty are derived from level.
- Reset asserted mid-frame aborts the frame and empties the FIFO. No pulse is generated.

Optional Feature:
UART_RX_PARITY_EN: adds parameter PARITY_ODD (default 0) and the PARITY state. The parity bit is sampled 16 ticks after the last data bit. On mismatch, parity_err pulses in the stop-sample cycle, the byte is discarded, and the stop bit is still checked. If both errors occur, both pulse together.
Without the macro: no PARITY state, DATA goes directly to STOP, and parity_err is tied 0.

Decomposition:
- Package uart_pkg: FSM state enum; constants OVERSAMPLE=16 and MID_TICK=8.
- Natural sub-module: rx_sync_fifo, holding the storage, pointers, level, FWFT output and simultaneous push/pop handling.

Test Plan:
- cfg_div=1 (16 clk/bit); send 0xA5 with a valid stop bit -> m_valid=1, m_data=0xA5, level=1, no error pulses.
- rx low for 5 clk then high -> no push, busy returns to 0, no pulses.
- Send 0x3C with stop bit 0 and rx held low 40 clk -> one frame_err pulse, level unchanged, next frame 0x11 is received correctly.
- FIFO_DEPTH=8, m_ready=0, send 0x00..0x08 -> level=8, one overrun pulse, ovr_cnt=1. Drain with m_ready=1 -> 0x00..0x07 in order.
- Full FIFO with m_ready=1 held while frame 0x55 completes -> push and pop in the same cycle, level stays 8, no overrun.
- UART_RX_PARITY_EN defined, PARITY_ODD=0, send 0x07 with parity bit 0 -> parity_err pulse, no push. Then send cfg_div=2 and 0x80 with correct parity -> m_data=0x80.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver:
//   - OVERSAMPLE : ticks per bit period
//   - MID_TICK   : tick index (1-based) at which the start bit is re-checked
//   - rx_state_e : receiver FSM state encoding
// Optional feature macro: UART_RX_PARITY_EN (adds ST_PARITY).
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY  = 3'd3,
`endif
    ST_STOP    = 3'd4,
    ST_WAIT_HI = 3'd5
  } rx_state_e;

endpackage

// File: rtl/rx_sync_fifo.sv
// ---------------------------------------------------------------------------
// rx_sync_fifo
// Single-clock first-word-fallthrough FIFO for received characters.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push_i      : write request (dropped when full unless popping same cycle)
//   wdata_i     : write data
//   pop_i       : consumer ready; a pop only happens when non-empty
//   rdata_o     : registered head of FIFO (0 after reset)
//   valid_o     : FIFO non-empty
//   full_o      : FIFO holds DEPTH entries
//   level_o     : occupancy
// ---------------------------------------------------------------------------
module rx_sync_fifo
  import uart_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [W-1:0]     wdata_i,
  input  logic             pop_i,
  output logic [W-1:0]     rdata_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [CNT_W-1:0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] level_q, level_d;
  logic [W-1:0]     rdata_q, rdata_d;
  logic             do_push, do_pop, full;

  assign full    = (level_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && (level_q != '0);
  // A full FIFO still accepts a write when a read frees a slot this cycle.
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    level_d  = level_q + CNT_W'(do_push) - CNT_W'(do_pop);
    rdata_d  = rdata_q;
    if (level_d != '0) begin
      // New head is the word being written only when nothing older remains.
      if (do_push && (rd_ptr_d == wr_ptr_q)) begin
        rdata_d = wdata_i;
      end else begin
        rdata_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
  assign valid_o = (level_q != '0);
  assign full_o  = full;
  assign level_o = level_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// UART receiver, 16x oversampling, runtime baud divisor, integrated FWFT FIFO.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   rx          : serial input (idle high, asynchronous)
//   cfg_div     : clk cycles per 1/16 bit (0 behaves as 1), latched in IDLE
//   m_data      : head-of-FIFO character, LSB = first bit on the line
//   m_valid     : FIFO non-empty; m_ready accepts
//   level       : FIFO occupancy
//   frame_err   : pulse, stop bit sampled low
//   parity_err  : pulse, parity mismatch (0 without the parity feature)
//   overrun     : pulse, good character dropped because FIFO full
//   ovr_cnt     : saturating overrun count
//   busy        : receiver not idle
// Optional feature macro: UART_RX_PARITY_EN (adds PARITY_ODD and a parity bit).
// ---------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
`ifdef UART_RX_PARITY_EN
  , parameter int PARITY_ODD = 0
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic [DIV_W-1:0]     cfg_div,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [CNT_W-1:0]     level,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic [7:0]           ovr_cnt,
  output logic                 busy
);

  rx_state_e state_q, state_d;

  logic                 rx_s1_q, rx_s2_q, rx_sync;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [DIV_W-1:0]     tcnt_q, tcnt_d;
  logic [3:0]           scnt_q, scnt_d;
  logic [3:0]           bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 push_q, push_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic [7:0]           ovr_cnt_q, ovr_cnt_d;
  logic                 tick, sample;
  logic                 fifo_full;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
`endif

  assign rx_sync = rx_s2_q;
  assign tick    = (tcnt_q == div_q - 1'b1);
  // Bit-period sample point: last tick of a 16-tick window.
  assign sample  = tick && (scnt_q == 4'(OVERSAMPLE - 1));

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    tcnt_d      = tick ? '0 : tcnt_q + 1'b1;
    scnt_d      = tick ? scnt_q + 1'b1 : scnt_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        tcnt_d   = '0;
        scnt_d   = '0;
        bitcnt_d = '0;
        div_d    = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (!rx_sync) state_d = ST_START;
      end
      ST_START: begin
        if (tick && (scnt_q == 4'(MID_TICK - 1))) begin
          scnt_d  = '0;
          state_d = rx_sync ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (sample) begin
          shift_d  = {rx_sync, shift_q[DATA_BITS-1:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 4'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (sample) begin
          // Even parity: data ^ parity bit must be 0; odd parity: 1.
          par_bad_d = ((^shift_q) ^ rx_sync) != PARITY_ODD[0];
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (sample) begin
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_bad_q;
`endif
          if (rx_sync) begin
`ifdef UART_RX_PARITY_EN
            push_d = !par_bad_q;
`else
            push_d = 1'b1;
`endif
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_WAIT_HI;
          end
        end
      end
      ST_WAIT_HI: begin
        // Hold here through a line break so it reports only one error.
        if (rx_sync) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Overrun only when the FIFO cannot make room this cycle.
  always_comb begin
    overrun_d = push_q && fifo_full && !m_ready;
    ovr_cnt_d = ovr_cnt_q;
    if (overrun_d && (ovr_cnt_q != 8'hFF)) ovr_cnt_d = ovr_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      div_q       <= DIV_W'(1);
      tcnt_q      <= '0;
      scnt_q      <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      ovr_cnt_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rx_s1_q     <= rx;
      rx_s2_q     <= rx_s1_q;
      div_q       <= div_d;
      tcnt_q      <= tcnt_d;
      scnt_q      <= scnt_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      ovr_cnt_q   <= ovr_cnt_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  rx_sync_fifo #(
    .W     (DATA_BITS),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_q),
    .wdata_i (shift_q),
    .pop_i   (m_ready),
    .rdata_o (m_data),
    .valid_o (m_valid),
    .full_o  (fifo_full),
    .level_o (level)
  );

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign ovr_cnt   = ovr_cnt_q;
  assign busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int DIV_W      = 16;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS   = 1;
`else
  localparam int PAR_BITS   = 0;
`endif
  // Start-bit drive edge to the edge where the FIFO sees the push:
  // 2 sync flops + 1 detect + 8 ticks to mid start + 16 per later bit.
  localparam int PUSH_OFS   = 11 + 16 * (DATA_BITS + PAR_BITS + 1);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 rx = 1'b1;
  logic                 m_ready = 1'b0;
  logic [DIV_W-1:0]     cfg_div = DIV_W'(1);
  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic [CNT_W-1:0]     level;
  logic                 frame_err, parity_err, overrun, busy;
  logic [7:0]           ovr_cnt;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .cfg_div    (cfg_div),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .level      (level),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .ovr_cnt    (ovr_cnt),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: characters expected in the FIFO, and expected event totals.
  logic [7:0] exp_q[$];
  int exp_ferr = 0, exp_perr = 0, exp_ovr = 0, ovr_since_rst = 0;
  int seen_ferr = 0, seen_perr = 0, seen_ovr = 0, seen_both = 0;
  logic       hold_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle compare process on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) seen_ferr++;
      if (parity_err) seen_perr++;
      if (overrun) seen_ovr++;
      if (frame_err && parity_err) seen_both++;
      check("valid_vs_level", 32'(m_valid), 32'(level != '0));
      if (hold_prev && m_valid) check("fwft_stable", 32'(m_data), 32'(prev_data));
      if (m_valid && m_ready) begin
        check("pop_model_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check("pop_data", 32'(m_data), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
      hold_prev <= m_valid && !m_ready;
      prev_data <= m_data;
    end else begin
      hold_prev <= 1'b0;
    end
  end

  task automatic hold_rx(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one frame; then updates the model with the outcome it implies.
  task automatic send_frame(input logic [7:0] d, input int div_eff,
                            input logic stop_bit, input logic par_flip);
    int bc;
    bc = 16 * div_eff;
    hold_rx(1'b0, bc);
    for (int i = 0; i < DATA_BITS; i++) hold_rx(d[i], bc);
`ifdef UART_RX_PARITY_EN
    hold_rx((^d) ^ par_flip, bc);
`endif
    hold_rx(stop_bit, bc);
    if (!stop_bit) hold_rx(1'b0, 40);
    hold_rx(1'b1, bc);
    if (!stop_bit) exp_ferr++;
    if (par_flip) exp_perr++;
    if (stop_bit && !par_flip) begin
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(d);
      else begin
        exp_ovr++;
        ovr_since_rst++;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_level"}, 32'(level), 32'(exp_q.size()));
    check({tag, "_valid"}, 32'(m_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check({tag, "_head"}, 32'(m_data), 32'(exp_q[0]));
    check({tag, "_ferr_cnt"}, 32'(seen_ferr), 32'(exp_ferr));
    check({tag, "_perr_cnt"}, 32'(seen_perr), 32'(exp_perr));
    check({tag, "_ovr_cnt"}, 32'(seen_ovr), 32'(exp_ovr));
    check({tag, "_ovr_reg"}, 32'(ovr_cnt), 32'((ovr_since_rst > 255) ? 255 : ovr_since_rst));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    $display("txn %s: level=%0d head=0x%0h ferr=%0d perr=%0d ovr=%0d ovr_cnt=%0d",
             tag, level, m_data, seen_ferr, seen_perr, seen_ovr, ovr_cnt);
  endtask

  task automatic drain(input string tag);
    m_ready = 1'b1;
    for (int i = 0; i < 4 * FIFO_DEPTH; i++) begin
      if (!m_valid) break;
      @(posedge clk);
      #1;
    end
    m_ready = 1'b0;
    check({tag, "_drained"}, 32'(m_valid), 32'd0);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_pulses", 32'({frame_err, parity_err, overrun}), 32'd0);
    check("rst_ovr_cnt", 32'(ovr_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    hold_rx(1'b1, 4);

    // Basic frame, 16 clk per bit.
    send_frame(8'hA5, 1, 1'b1, 1'b0);
    check("a5_data_lit", 32'(m_data), 32'hA5);
    check("a5_level_lit", 32'(level), 32'd1);
    check_idle("a5");
    drain("a5");

    // Short glitch on the line is not a start bit.
    hold_rx(1'b0, 5);
    check("glitch_busy", 32'(busy), 32'd1);
    hold_rx(1'b1, 30);
    check_idle("glitch");

    // Bad stop bit with held-low line, then a good frame.
    send_frame(8'h3C, 1, 1'b0, 1'b0);
    check("ferr_once_lit", 32'(seen_ferr), 32'd1);
    check_idle("ferr");
    send_frame(8'h11, 1, 1'b1, 1'b0);
    check("after_ferr_lit", 32'(m_data), 32'h11);
    check_idle("after_ferr");
    drain("after_ferr");

    // Fill past full with no consumer.
    for (int i = 0; i <= FIFO_DEPTH; i++) send_frame(8'(i), 1, 1'b1, 1'b0);
    check("full_level_lit", 32'(level), 32'd8);
    check("full_ovr_lit", 32'(ovr_cnt), 32'd1);
    check_idle("overrun");

    // Push and pop in the same cycle while full.
    fork
      send_frame(8'h55, 1, 1'b1, 1'b0);
      begin
        repeat (PUSH_OFS) @(posedge clk);
        #1 m_ready = 1'b1;
        @(posedge clk);
        #1 m_ready = 1'b0;
      end
    join
    check("pushpop_level_lit", 32'(level), 32'd8);
    check_idle("pushpop");

    // Saturate the overrun counter.
    for (int i = 0; i < 255; i++) send_frame(8'(i + 8'h80), 1, 1'b1, 1'b0);
    check("ovr_sat_lit", 32'(ovr_cnt), 32'd255);
    check_idle("ovr_sat");
    drain("ovr_sat");
    check_idle("drained");

    // Runtime divisors, zero divisor, mid-frame divisor change.
    cfg_div = DIV_W'(2);
    send_frame(8'h80, 2, 1'b1, 1'b0);
    check("div2_data_lit", 32'(m_data), 32'h80);
    check_idle("div2");
    cfg_div = DIV_W'(0);
    send_frame(8'h5A, 1, 1'b1, 1'b0);
    check_idle("div0");
    cfg_div = DIV_W'(1);
    fork
      send_frame(8'hC3, 1, 1'b1, 1'b0);
      begin
        repeat (60) @(posedge clk);
        #1 cfg_div = DIV_W'(3);
      end
    join
    send_frame(8'h96, 3, 1'b1, 1'b0);
    check_idle("div_change");
    drain("div_change");

`ifdef UART_RX_PARITY_EN
    cfg_div = DIV_W'(1);
    send_frame(8'h07, 1, 1'b1, 1'b1);
    check("perr_once_lit", 32'(seen_perr), 32'd1);
    check_idle("parity_bad");
    cfg_div = DIV_W'(2);
    send_frame(8'h80, 2, 1'b1, 1'b0);
    check("parity_ok_lit", 32'(m_data), 32'h80);
    check_idle("parity_ok");
    cfg_div = DIV_W'(1);
    send_frame(8'h33, 1, 1'b0, 1'b1);
    check("both_err_lit", 32'(seen_both), 32'd1);
    check_idle("both_err");
    drain("parity");
`endif

    // Reset in the middle of a frame with a character stored.
    cfg_div = DIV_W'(1);
    send_frame(8'h42, 1, 1'b1, 1'b0);
    check_idle("pre_reset");
    hold_rx(1'b0, 60);
    rst_n = 1'b0;
    rx = 1'b1;
    exp_q.delete();
    ovr_since_rst = 0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_data", 32'(m_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    hold_rx(1'b1, 40);
    check_idle("post_reset");
    send_frame(8'hE1, 1, 1'b1, 1'b0);
    check("post_reset_lit", 32'(m_data), 32'hE1);
    check_idle("post_reset_frame");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
